// File: rtl/timer_pkg.sv
// Shared types and constants for the memory-mapped timer / interrupt sequencer.
// Optional prescaler register offset is only decoded when TIMER_PRESCALE_EN is defined.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timer_state_e;

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESET   = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_PRESCALE = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    // Byte-lane merge of a CPU write into an existing 32-bit register.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the countdown: tick fires every prescale+1 enabled cycles.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] div_r;

    // >= keeps the divider bounded if prescale is lowered mid-count
    assign tick = enable && (div_r >= prescale);

    // Divider counter, restarted on every reload
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= 16'd0;
        end else if (clear) begin
            div_r <= 16'd0;
        end else if (enable) begin
            div_r <= tick ? 16'd0 : div_r + 16'd1;
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped countdown timer with interrupt sequencing (CTRL/PRESET/COUNT).
// Define TIMER_PRESCALE_EN to add the PRESCALE register at +0xC and the divider.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7F00,
    parameter bit          MODE1_RELOAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irq
);

    timer_state_e state_r;
    timer_state_e state_s;
    logic [3:0]   ctrl_r;
    logic [31:0]  preset_r;
    logic [31:0]  count_r;
    logic         irq_flag_r;

    logic         wr_s;
    logic         ctrl_wr_s;
    logic         preset_wr_s;
    logic         en_s;
    logic         periodic_s;
    logic         tick_s;
    logic         expire_s;
    logic         addr_lsb_unused_s;

    assign addr_lsb_unused_s = ^addr[1:0];

`ifdef TIMER_PRESCALE_EN
    assign sel = (addr[31:4] == BASE_ADDR[31:4]);
`else
    assign sel = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != OFF_PRESCALE);
`endif

    assign wr_s        = sel && (byteen != 4'd0);
    assign ctrl_wr_s   = wr_s && (addr[3:2] == OFF_CTRL);
    assign preset_wr_s = wr_s && (addr[3:2] == OFF_PRESET);
    assign en_s        = ctrl_r[CTRL_EN_BIT];
    // Modes 2/3 and non-reloading mode 1 all behave as one-shot
    assign periodic_s  = (ctrl_r[CTRL_MODE_LSB +: 2] == MODE_PERIODIC) && MODE1_RELOAD;
    assign expire_s    = (state_r == CNT) && en_s && tick_s && (count_r <= 32'd1);
    assign irq         = irq_flag_r & ctrl_r[CTRL_IM_BIT];

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_r;

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_r == LOAD),
        .enable   ((state_r == CNT) && en_s),
        .prescale (prescale_r),
        .tick     (tick_s)
    );

    // PRESCALE register, low two byte lanes only
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_r <= 16'd0;
        end else if (wr_s && (addr[3:2] == OFF_PRESCALE)) begin
            prescale_r[7:0]  <= byteen[0] ? wdata[7:0]  : prescale_r[7:0];
            prescale_r[15:8] <= byteen[1] ? wdata[15:8] : prescale_r[15:8];
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (en_s) state_s = LOAD; else state_s = IDLE;
            LOAD:    if (en_s) state_s = CNT;  else state_s = IDLE;
            CNT: begin
                if (!en_s) begin
                    state_s = IDLE;
                end else if (tick_s && (count_r <= 32'd1)) begin
                    state_s = INT;
                end else begin
                    state_s = CNT;
                end
            end
            INT:     if (periodic_s) state_s = LOAD; else state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // CTRL: a CPU write takes priority over the one-shot EN clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r <= 4'd0;
        end else if (ctrl_wr_s) begin
            ctrl_r <= byteen[0] ? wdata[3:0] : ctrl_r;
        end else if ((state_r == INT) && !periodic_s) begin
            ctrl_r[CTRL_EN_BIT] <= 1'b0;
        end
    end

    // PRESET: only sampled into COUNT at LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            preset_r <= 32'd0;
        end else if (preset_wr_s) begin
            preset_r <= byte_merge(preset_r, wdata, byteen);
        end
    end

    // COUNT: saturates at zero rather than wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 32'd0;
        end else if (state_r == LOAD) begin
            count_r <= preset_r;
        end else if ((state_r == CNT) && en_s && tick_s) begin
            count_r <= (count_r <= 32'd1) ? 32'd0 : count_r - 32'd1;
        end
    end

    // Interrupt flag: set on expiry, acked by any CTRL write, one cycle in periodic mode
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            irq_flag_r <= 1'b0;
        end else if (expire_s) begin
            irq_flag_r <= 1'b1;
        end else if ((state_r == INT) && periodic_s) begin
            irq_flag_r <= 1'b0;
        end
    end

    // Read mux
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr[3:2])
                OFF_CTRL:     rdata = {28'd0, ctrl_r};
                OFF_PRESET:   rdata = preset_r;
                OFF_COUNT:    rdata = count_r;
`ifdef TIMER_PRESCALE_EN
                OFF_PRESCALE: rdata = {16'd0, prescale_r};
`endif
                default:      rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

endmodule
